// File: rtl/ddr3_wb_arbiter.sv
// ddr3_wb_arbiter: two-master arbiter for the single pipelined Wishbone port
// of ddr3_top. A master owns the port for the whole of its cyc assertion.
// Acks are routed to the owner, and read data is broadcast to both masters.
// An outstanding-request counter stops the owner from exceeding the
// controller pipeline depth of 2**LGMAXOUT-1.
//
// Ports:
//   i_controller_clk, i_rst_n        clock and asynchronous active-low reset
//   i_m{0,1}_cyc/stb/we/addr/data/sel  master request side
//   o_m{0,1}_stall/ack/data            master response side
//   o_wb_cyc/stb/we/addr/data/sel      towards ddr3_top
//   i_wb_stall/ack/data                from ddr3_top
//   o_owner                            {valid, index} of the current owner
//
// Build option: ARB_FIXED_PRIORITY_EN makes m0 win every arbitration.
// When it is left undefined, arbitration is round-robin.
module ddr3_wb_arbiter #(
  parameter int unsigned ADDR_BITS = 24,
  parameter int unsigned DATA_BITS = 128,
  parameter int unsigned SEL_BITS  = DATA_BITS / 8,
  parameter int unsigned LGMAXOUT  = 4
) (
  input  logic                 i_controller_clk,
  input  logic                 i_rst_n,
  // master 0
  input  logic                 i_m0_cyc,
  input  logic                 i_m0_stb,
  input  logic                 i_m0_we,
  input  logic [ADDR_BITS-1:0] i_m0_addr,
  input  logic [DATA_BITS-1:0] i_m0_data,
  input  logic [SEL_BITS-1:0]  i_m0_sel,
  output logic                 o_m0_stall,
  output logic                 o_m0_ack,
  output logic [DATA_BITS-1:0] o_m0_data,
  // master 1
  input  logic                 i_m1_cyc,
  input  logic                 i_m1_stb,
  input  logic                 i_m1_we,
  input  logic [ADDR_BITS-1:0] i_m1_addr,
  input  logic [DATA_BITS-1:0] i_m1_data,
  input  logic [SEL_BITS-1:0]  i_m1_sel,
  output logic                 o_m1_stall,
  output logic                 o_m1_ack,
  output logic [DATA_BITS-1:0] o_m1_data,
  // slave (ddr3_top)
  output logic                 o_wb_cyc,
  output logic                 o_wb_stb,
  output logic                 o_wb_we,
  output logic [ADDR_BITS-1:0] o_wb_addr,
  output logic [DATA_BITS-1:0] o_wb_data,
  output logic [SEL_BITS-1:0]  o_wb_sel,
  input  logic                 i_wb_stall,
  input  logic                 i_wb_ack,
  input  logic [DATA_BITS-1:0] i_wb_data,
  output logic [1:0]           o_owner
);

  localparam int unsigned CNT_W = LGMAXOUT;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;  // 2**LGMAXOUT-1

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT0 = 2'd1,
    S_GRANT1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] outcnt_q, outcnt_d;
  logic             full_c;
  logic             cnt_nz_c;
  logic             own_cyc_c;
  logic             issue_c;
  logic             ack_cnt_c;

`ifndef ARB_FIXED_PRIORITY_EN
  // Index of the most recent owner; the other master wins the next tie.
  logic             last_q, last_d;
`endif

  assign full_c   = (outcnt_q == CNT_MAX);
  assign cnt_nz_c = (outcnt_q != '0);

  // Read data goes to both masters; only the owner receives an ack.
  assign o_m0_data = i_wb_data;
  assign o_m1_data = i_wb_data;

  // State, last-owner and outstanding counter registers.
  always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      outcnt_q <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      outcnt_q <= outcnt_d;
`ifndef ARB_FIXED_PRIORITY_EN
      last_q   <= last_d;
`endif
    end
  end

  // Next-state, counter update and port mux.
  always_comb begin
    state_d    = state_q;
    outcnt_d   = outcnt_q;
`ifndef ARB_FIXED_PRIORITY_EN
    last_d     = last_q;
`endif
    o_wb_cyc   = 1'b0;
    o_wb_stb   = 1'b0;
    o_wb_we    = 1'b0;
    o_wb_addr  = '0;
    o_wb_data  = '0;
    o_wb_sel   = '0;
    o_m0_stall = 1'b1;
    o_m0_ack   = 1'b0;
    o_m1_stall = 1'b1;
    o_m1_ack   = 1'b0;
    o_owner    = 2'b00;
    own_cyc_c  = 1'b0;
    issue_c    = 1'b0;
    ack_cnt_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        outcnt_d = '0;
`ifdef ARB_FIXED_PRIORITY_EN
        if (i_m0_cyc) begin
          state_d = S_GRANT0;
        end else if (i_m1_cyc) begin
          state_d = S_GRANT1;
        end
`else
        if (i_m0_cyc && i_m1_cyc) begin
          state_d = last_q ? S_GRANT0 : S_GRANT1;
          last_d  = ~last_q;
        end else if (i_m0_cyc) begin
          state_d = S_GRANT0;
          last_d  = 1'b0;
        end else if (i_m1_cyc) begin
          state_d = S_GRANT1;
          last_d  = 1'b1;
        end
`endif
      end

      S_GRANT0: begin
        own_cyc_c  = i_m0_cyc;
        o_owner    = 2'b10;
        o_wb_cyc   = i_m0_cyc;
        o_wb_stb   = i_m0_cyc & i_m0_stb & ~full_c;
        o_wb_we    = i_m0_we;
        o_wb_addr  = i_m0_addr;
        o_wb_data  = i_m0_data;
        o_wb_sel   = i_m0_sel;
        o_m0_stall = i_wb_stall | full_c;
        o_m0_ack   = i_wb_ack & cnt_nz_c;
        ack_cnt_c  = i_wb_ack & cnt_nz_c;
      end

      S_GRANT1: begin
        own_cyc_c  = i_m1_cyc;
        o_owner    = 2'b11;
        o_wb_cyc   = i_m1_cyc;
        o_wb_stb   = i_m1_cyc & i_m1_stb & ~full_c;
        o_wb_we    = i_m1_we;
        o_wb_addr  = i_m1_addr;
        o_wb_data  = i_m1_data;
        o_wb_sel   = i_m1_sel;
        o_m1_stall = i_wb_stall | full_c;
        o_m1_ack   = i_wb_ack & cnt_nz_c;
        ack_cnt_c  = i_wb_ack & cnt_nz_c;
      end

      default: begin
        state_d  = S_IDLE;
        outcnt_d = '0;
      end
    endcase

    issue_c = o_wb_stb & ~i_wb_stall;

    // The owner dropping cyc aborts the cycle. Acks that are still in
    // flight are forgotten, and the port always idles one clock.
    if (state_q == S_GRANT0 || state_q == S_GRANT1) begin
      if (!own_cyc_c) begin
        state_d  = S_IDLE;
        outcnt_d = '0;
      end else if (issue_c && !ack_cnt_c) begin
        outcnt_d = outcnt_q + CNT_W'(1);
      end else if (!issue_c && ack_cnt_c) begin
        outcnt_d = outcnt_q - CNT_W'(1);
      end
    end
  end

endmodule
